// File: rtl/pingpong_dpram_buffer.sv
// Two-bank ping-pong buffer over dual-port RAM banks with done-handshake bank swapping.
// Optional saturating error counters are built when PINGPONG_ERRCNT_EN is defined.

// One RAM bank: port A writes, port B does a registered read.
module pingpong_dpram_bank #(
    parameter int unsigned DWIDTH    = 40,
    parameter int unsigned AWIDTH    = 12,
    parameter int unsigned NUM_WORDS = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wren_a,
    input  logic [AWIDTH-1:0] addr_a,
    input  logic [DWIDTH-1:0] din_a,
    input  logic              rden_b,
    input  logic [AWIDTH-1:0] addr_b,
    output logic [DWIDTH-1:0] q_b
);
    logic [DWIDTH-1:0] mem [NUM_WORDS];

    always_ff @(posedge clk) begin
        if (wren_a) begin
            mem[addr_a] <= din_a;
        end
    end

    // The output register resets and holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_b <= '0;
        end else if (rden_b) begin
            q_b <= mem[addr_b];
        end
    end
endmodule

module pingpong_dpram_buffer #(
    parameter int unsigned DWIDTH    = 40,
    parameter int unsigned AWIDTH    = 12,
    parameter int unsigned NUM_WORDS = 4096,
    parameter int unsigned ERRW      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_done,
    output logic              wr_ready,
    output logic              wr_bank,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    input  logic              rd_done,
    output logic              rd_avail,
    output logic              rd_bank,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic [ERRW-1:0]   err_drop_wr,
    output logic [ERRW-1:0]   err_bad_rd
);
    logic [1:0]        full_q, full_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_acc, rd_acc;
    logic [DWIDTH-1:0] bank_q [2];

    // Handshake outputs are pure decodes of registered state.
    assign wr_ready = ~full_q[wr_ptr_q];
    assign rd_avail = full_q[rd_ptr_q];
    assign wr_bank  = wr_ptr_q;
    assign rd_bank  = rd_ptr_q;
    assign wr_acc   = wr_en & wr_ready & ~reset;
    assign rd_acc   = rd_en & rd_avail & ~reset;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_sel_q ? bank_q[1] : bank_q[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q     <= 2'b00;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_sel_q   <= rd_sel_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Both dones may apply together; when both qualify they address different banks.
    always_comb begin
        full_d     = full_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_sel_d   = rd_sel_q;
        rd_valid_d = rd_acc;
        if (rd_acc) begin
            rd_sel_d = rd_ptr_q;
        end
        if (wr_done && wr_ready) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (rd_done && rd_avail) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pingpong_dpram_bank #(
            .DWIDTH   (DWIDTH),
            .AWIDTH   (AWIDTH),
            .NUM_WORDS(NUM_WORDS)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .wren_a(wr_acc && (wr_ptr_q == 1'(b))),
            .addr_a(wr_addr),
            .din_a (wr_data),
            .rden_b(rd_acc && (rd_ptr_q == 1'(b))),
            .addr_b(rd_addr),
            .q_b   (bank_q[b])
        );
    end

`ifdef PINGPONG_ERRCNT_EN
    logic [ERRW-1:0] drop_q, bad_q;

    // Saturating counts of refused writes and reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
            bad_q  <= '0;
        end else begin
            if (wr_en && !wr_ready && (drop_q != '1)) begin
                drop_q <= drop_q + ERRW'(1);
            end
            if (rd_en && !rd_avail && (bad_q != '1)) begin
                bad_q <= bad_q + ERRW'(1);
            end
        end
    end

    assign err_drop_wr = drop_q;
    assign err_bad_rd  = bad_q;
`else
    assign err_drop_wr = '0;
    assign err_bad_rd  = '0;
`endif
endmodule

// File: tb/tb_pingpong_dpram_buffer.sv
// Self-checking bench for pingpong_dpram_buffer: directed plan steps plus random traffic
// compared against a bank-count reference model.
module tb_pingpong_dpram_buffer;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned NW = 16;
    localparam int unsigned EW = 2;
    localparam int          CMAX = 3;

    logic          clk = 1'b0;
    logic          reset, wr_en, wr_done, rd_en, rd_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready, wr_bank, rd_avail, rd_bank, rd_valid;
    logic [DW-1:0] rd_data;
    logic [EW-1:0] err_drop_wr, err_bad_rd;

    always #5 clk = ~clk;

    pingpong_dpram_buffer #(.DWIDTH(DW), .AWIDTH(AW), .NUM_WORDS(NW), .ERRW(EW)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .wr_ready(wr_ready), .wr_bank(wr_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
        .rd_avail(rd_avail), .rd_bank(rd_bank), .rd_data(rd_data), .rd_valid(rd_valid),
        .err_drop_wr(err_drop_wr), .err_bad_rd(err_bad_rd)
    );

    // Reference model: number of full banks n and the next bank to consume rp.
    // The producer bank is always (rp + n) mod 2.
    int            n, rp, drop_cnt, bad_cnt;
    logic [DW-1:0] mmem [2][NW];
    bit            mknown [2][NW];
    logic [DW-1:0] exp_data;
    bit            exp_known, exp_valid;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_exp(input int v);
`ifdef PINGPONG_ERRCNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check_all();
        chk("wr_ready", 32'(wr_ready), 32'(n < 2));
        chk("rd_avail", 32'(rd_avail), 32'(n > 0));
        chk("wr_bank", 32'(wr_bank), 32'((rp + n) % 2));
        chk("rd_bank", 32'(rd_bank), 32'(rp));
        chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
        if (exp_known) chk("rd_data", 32'(rd_data), 32'(exp_data));
        chk("err_drop_wr", 32'(err_drop_wr), 32'(cnt_exp(drop_cnt)));
        chk("err_bad_rd", 32'(err_bad_rd), 32'(cnt_exp(bad_cnt)));
    endtask

    task automatic cycle(input bit rst, input bit we, input int wa, input int wd, input bit wdn,
                         input bit re, input int ra, input bit rdn);
        int wb;
        bit wt, rt;
        reset = rst; wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd); wr_done = wdn;
        rd_en = re; rd_addr = AW'(ra); rd_done = rdn;
        if (rst) begin
            n = 0; rp = 0; exp_valid = 0; exp_data = '0; exp_known = 1; drop_cnt = 0; bad_cnt = 0;
        end else begin
            wb = (rp + n) % 2;
            exp_valid = 0;
            if (re && n > 0) begin
                exp_valid = 1;
                exp_known = mknown[rp][ra];
                exp_data  = mmem[rp][ra];
            end else if (re && bad_cnt < CMAX) begin
                bad_cnt++;
            end
            if (we && n < 2) begin
                mmem[wb][wa] = DW'(wd);
                mknown[wb][wa] = 1;
            end else if (we && drop_cnt < CMAX) begin
                drop_cnt++;
            end
            wt = wdn && n < 2;
            rt = rdn && n > 0;
            n = n + int'(wt) - int'(rt);
            if (rt) rp = rp ^ 1;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; wr_en = 0; wr_addr = '0; wr_data = '0; wr_done = 0;
        rd_en = 0; rd_addr = '0; rd_done = 0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < int'(NW); a++) mknown[b][a] = 0;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_rd_avail", 32'(rd_avail), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);

        // Fill bank 0 then read it back.
        for (int i = 0; i < 4; i++) cycle(0, 1, i, 8'h11 * (i + 1), 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t1_wr_bank", 32'(wr_bank), 32'd1);
        chk("t1_rd_avail", 32'(rd_avail), 32'd1);
        cycle(0, 0, 0, 0, 0, 1, 2, 0);
        chk("t1_rd_data", 32'(rd_data), 32'h33);
        chk("t1_rd_valid", 32'(rd_valid), 32'd1);

        // Both banks full: write is dropped until the consumer releases a bank.
        cycle(0, 1, 5, 8'h55, 1, 0, 0, 0);
        chk("t2_wr_ready", 32'(wr_ready), 32'd0);
        cycle(0, 1, 5, 8'h5A, 0, 0, 0, 0);
        chk("t2_drop", 32'(err_drop_wr), 32'(cnt_exp(1)));
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t2_wr_ready_after", 32'(wr_ready), 32'd1);
        chk("t2_wr_bank_after", 32'(wr_bank), 32'd0);

        // Simultaneous done while bank 0 is full and bank 1 is being filled.
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 1, 1, 8'h77, 1, 0, 0, 0);
        cycle(0, 1, 0, 8'h99, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 1);
        chk("t3_rd_bank", 32'(rd_bank), 32'd1);
        chk("t3_wr_bank", 32'(wr_bank), 32'd0);
        chk("t3_flags", 32'({rd_avail, wr_ready}), 32'b11);
        cycle(0, 0, 0, 0, 0, 1, 5, 0);
        chk("t3_dropped_not_written", 32'(rd_data), 32'h55);

        // Refused read holds data; refused dones change nothing.
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 3, 0);
        chk("t4_rd_valid", 32'(rd_valid), 32'd0);
        chk("t4_rd_hold", 32'(rd_data), 32'h55);
        chk("t4_bad", 32'(err_bad_rd), 32'(cnt_exp(1)));
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t4_stalled", 32'({wr_ready, wr_bank, rd_bank}), 32'b000);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // Write coincident with done lands in the old bank; reset cancels a read.
        cycle(0, 1, 7, 8'hAB, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 7, 0);
        chk("t5_rd_data", 32'(rd_data), 32'hAB);
        cycle(1, 0, 0, 0, 0, 1, 7, 0);
        chk("t5_rst_valid", 32'(rd_valid), 32'd0);
        chk("t5_rst_flags", 32'({wr_ready, rd_avail}), 32'b10);

        // Full-depth fill and read-back, then saturate the drop counter.
        for (int i = 0; i < int'(NW); i++) cycle(0, 1, i, i, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < int'(NW); i++) begin
            cycle(0, 0, 0, 0, 0, 1, i, 0);
            chk("t6_readback", 32'(rd_data), 32'(i));
        end
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, i, 8'hEE, 0, 0, 0, 0);
        chk("t6_sat", 32'(err_drop_wr), 32'(cnt_exp(3)));

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            automatic bit rst = ($urandom_range(99) == 0);
            cycle(rst, !rst && $urandom_range(1) == 1, int'($urandom_range(NW - 1)),
                  int'($urandom_range(255)), $urandom_range(7) == 0,
                  $urandom_range(1) == 1, int'($urandom_range(NW - 1)), $urandom_range(7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pingpong_dpram_buffer.md
Name: pingpong_dpram_buffer

Overview:
Parametrised two-bank ping-pong buffer built from two internal dual-port RAM banks, each NUM_WORDS x DWIDTH.
- A producer fills one bank while a consumer drains the other.
- Bank ownership swaps on explicit done handshakes, not on a free-running toggle.
- Sits between compute stages, e.g. as an activation or weight tile buffer, to overlap load and compute.

Parameters:
DWIDTH, 40, data word width in bits
AWIDTH, 12, address width; must satisfy 2**AWIDTH >= NUM_WORDS
NUM_WORDS, 4096, words per bank
ERRW, 16, width of the error counters (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe into the producer bank
wr_addr  in  AWIDTH  write address
wr_data  in  DWIDTH  write data
wr_done  in  1  producer finished its bank; pulse for 1 cycle
wr_ready  out  1  a bank is owned by the producer; writes are accepted
wr_bank  out  1  index of the producer bank
rd_en  in  1  read strobe from the consumer bank
rd_addr  in  AWIDTH  read address
rd_done  in  1  consumer finished its bank; pulse for 1 cycle
rd_avail  out  1  a full bank is owned by the consumer
rd_bank  out  1  index of the consumer bank
rd_data  out  DWIDTH  read data
rd_valid  out  1  rd_data is valid
err_drop_wr  out  ERRW  dropped-write count (optional feature)
err_bad_rd  out  ERRW  invalid-read count (optional feature)

Behaviour:
- Clock and reset: the clock is clk. Reset is synchronous and active-high on reset.
- State: full[1:0] (one bit per bank), wr_ptr, rd_ptr. wr_bank = wr_ptr; rd_bank = rd_ptr.
- Ready/avail: wr_ready = ~full[wr_ptr]; rd_avail = full[rd_ptr].
- Reset: full=00, wr_ptr=0, rd_ptr=0.
  - Outputs: wr_ready=1, rd_avail=0, rd_valid=0, rd_data=0, counters=0.
  - RAM contents are not cleared.
- Reset mid-operation: discards all bank ownership. A read in flight produces no rd_valid.
- Write:
  - wr_en & wr_ready writes wr_data to bank wr_ptr at wr_addr, visible to reads from the next cycle.
  - wr_en & ~wr_ready: write dropped, RAM unchanged.
- wr_done & wr_ready: full[wr_ptr] <= 1 and wr_ptr toggles.
  - A write in the same cycle lands in the old bank before the swap.
  - wr_done & ~wr_ready is ignored.
- Read:
  - rd_en & rd_avail reads bank rd_ptr at rd_addr.
  - rd_data is registered with 1-cycle latency; rd_valid=1 on the following cycle.
  - rd_en & ~rd_avail gives rd_valid=0 next cycle and rd_data holds its previous value.
- rd_done & rd_avail: full[rd_ptr] <= 0 and rd_ptr toggles.
  - A read in the same cycle still returns old-bank data.
  - rd_done & ~rd_avail is ignored.
- Simultaneous done: wr_done and rd_done in the same cycle are both applied. They always target different banks, or the same bank only when it is impossible for both to qualify.
- Bank states:
  - Both empty: producer writing bank wr_ptr.
  - One full: producer on the other bank, consumer reading the full one.
  - Both full: wr_ready=0; producer stalls until rd_done.
- Pointer order: wr_ptr and rd_ptr advance independently in strict alternation, so banks are consumed in the order they were filled.
- Addresses >= NUM_WORDS: behaviour is undefined and is not checked.
- Internal RAM: each bank uses port A for writes and port B for reads. The other bank's ports are driven idle (wren=0).
- Combinational paths: wr_ready, rd_avail, wr_bank and rd_bank are registered-state decodes only, with no combinational path from inputs.

Optional Feature:
Macro PINGPONG_ERRCNT_EN.
- Defined:
  - err_drop_wr increments on each wr_en & ~wr_ready.
  - err_bad_rd increments on each rd_en & ~rd_avail.
  - Both saturate at all-ones and are cleared by reset.
- Undefined: both outputs are tied to 0 and no counter logic is generated.

Test Plan:
1. Reset, then write addr 0..3 = 0x11,0x22,0x33,0x44, wr_done -> wr_bank=1, wr_ready=1, rd_avail=1, rd_bank=0. Reading addr 2 gives rd_data=0x33, rd_valid=1 one cycle after rd_en.
2. Fill bank 0 and bank 1 (wr_done twice) with no rd_done -> wr_ready=0. Write to addr 5 is dropped, and err_drop_wr=1 if PINGPONG_ERRCNT_EN is defined. After rd_done, wr_ready=1 and wr_bank=0.
3. Bank 0 full, producer filling bank 1. Assert wr_done and rd_done in the same cycle -> full=10, rd_bank=1, wr_bank=0, rd_avail=1, wr_ready=1.
4. rd_en with rd_avail=0 -> rd_valid=0 next cycle and rd_data unchanged; err_bad_rd=1 with the macro. wr_done while wr_ready=0 and rd_done while rd_avail=0 -> no state change.
5. Write addr 7=0xAB in the same cycle as wr_done -> reading bank 0 addr 7 returns 0xAB. Assert reset mid-read -> rd_valid=0 next cycle, wr_ready=1, rd_avail=0.
6. With DWIDTH=8, AWIDTH=4, NUM_WORDS=16, fill all 16 addresses with their own index -> reads return 0..15. With the macro and ERRW=2, 5 dropped writes saturate err_drop_wr at 3.
